led_bank_driver: RTL and testbench

- Initiator side of the 12-bit LED-bank instruction interface; converts 8-bit "desired LED pattern" requests into the fewest instructions.
- Keeps a shadow copy of the LED bank's current value.
- Sits between the control logic (or a CPU register write) and the LED bank peripheral; drives its inst/inst_en pins directly.

---
 rtl/led_bank_driver_pkg.sv | 11 +
 rtl/led_bank_driver_if.sv | 19 +
 rtl/led_bank_inst_encode.sv | 25 ++
 rtl/led_bank_driver.sv | 133 +++++++++++++
 tb/tb_led_bank_driver.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/led_bank_driver_pkg.sv
// led_bank_driver_pkg: opcodes, instruction field layout and driver states shared with the LED bank
package led_bank_driver_pkg;
  localparam int CODE_W = 4;
  localparam int IMM_W = 8;
  localparam int INST_W = CODE_W + IMM_W;
  localparam logic [CODE_W-1:0] OP_NOP = 4'd0;
  localparam logic [CODE_W-1:0] OP_LDI = 4'd1;
  localparam logic [CODE_W-1:0] OP_LD0 = 4'd2;
  localparam logic [CODE_W-1:0] OP_LD7 = 4'd9;
  typedef enum logic [1:0] {ST_RESET, ST_IDLE, ST_ISSUE, ST_GAP} state_e;
endpackage

// File: rtl/led_bank_driver_if.sv
// led_bank_driver_if: request handshake plus LED-bank instruction pins; blink input added with LED_BANK_DRIVER_BLINK_EN
interface led_bank_driver_if;
  import led_bank_driver_pkg::*;
  logic req_valid;
  logic [IMM_W-1:0] req_value;
  logic req_ready;
  logic [INST_W-1:0] inst;
  logic inst_en;
  logic [IMM_W-1:0] shadow;
  logic busy;
`ifdef LED_BANK_DRIVER_BLINK_EN
  logic blink;
  modport master (input req_valid, req_value, blink, output req_ready, inst, inst_en, shadow, busy);
  modport slave (output req_valid, req_value, blink, input req_ready, inst, inst_en, shadow, busy);
`else
  modport master (input req_valid, req_value, output req_ready, inst, inst_en, shadow, busy);
  modport slave (output req_valid, req_value, input req_ready, inst, inst_en, shadow, busy);
`endif
endinterface

// File: rtl/led_bank_inst_encode.sv
// led_bank_inst_encode: picks the cheapest instruction moving the bank from shadow to value
module led_bank_inst_encode
  import led_bank_driver_pkg::*;
(
  input  logic [IMM_W-1:0]  shadow_i,
  input  logic [IMM_W-1:0]  value_i,
  output logic              need_issue_o,
  output logic [INST_W-1:0] inst_o
);
  logic [IMM_W-1:0] diff;
  logic [3:0] cnt;
  logic [2:0] k;
  // popcount of the changed bits and index of the lowest changed bit
  always_comb begin
    diff = shadow_i ^ value_i;
    cnt = '0;
    k = '0;
    for (int i = IMM_W - 1; i >= 0; i--) begin
      cnt = cnt + 4'(diff[i]);
      if (diff[i]) k = 3'(i);
    end
    need_issue_o = cnt != 4'd0;
    inst_o = cnt == 4'd1 ? {OP_LD0 + 4'(k), 7'b0, value_i[k]} : {OP_LDI, value_i};
  end
endmodule

// File: rtl/led_bank_driver.sv
// led_bank_driver: turns LED pattern requests into minimal bank instructions; LED_BANK_DRIVER_BLINK_EN adds blinking
module led_bank_driver
  import led_bank_driver_pkg::*;
#(
  parameter int GAP = 0
`ifdef LED_BANK_DRIVER_BLINK_EN
  , parameter int BLINK_PERIOD = 1024
`endif
) (
  input logic clk,
  input logic rst_n,
  led_bank_driver_if.master bus
);
  state_e state_q, state_d;
  logic [7:0] gap_q, gap_d;
  logic ready_q, ready_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic inst_en_q, inst_en_d;
  logic [IMM_W-1:0] shadow_q, shadow_d;
  logic acc;
  logic req_need;
  logic [INST_W-1:0] req_inst;
  led_bank_inst_encode u_req (.shadow_i(shadow_q), .value_i(bus.req_value), .need_issue_o(req_need), .inst_o(req_inst));
`ifdef LED_BANK_DRIVER_BLINK_EN
  localparam int BW = $clog2(BLINK_PERIOD);
  logic [IMM_W-1:0] target_q, target_d;
  logic blink_q;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic bpend_q, bpend_d;
  logic rpend_q, rpend_d;
  logic rst_need;
  logic [INST_W-1:0] rst_inst;
  led_bank_inst_encode u_restore (.shadow_i(shadow_q), .value_i(target_q), .need_issue_o(rst_need), .inst_o(rst_inst));
`endif
  assign bus.req_ready = ready_q;
  assign bus.busy = ~ready_q;
  assign bus.inst = inst_q;
  assign bus.inst_en = inst_en_q;
  assign bus.shadow = shadow_q;
  // next state, next instruction and registered handshake; pending blink work blocks new requests
  always_comb begin
    state_d = state_q;
    gap_d = gap_q;
    shadow_d = shadow_q;
    inst_d = '0;
    inst_en_d = 1'b0;
    acc = ready_q && bus.req_valid;
`ifdef LED_BANK_DRIVER_BLINK_EN
    target_d = acc ? bus.req_value : target_q;
    bcnt_d = bcnt_q;
    bpend_d = bpend_q;
    rpend_d = rpend_q;
`endif
    case (state_q)
      ST_RESET: state_d = ST_IDLE;
      ST_IDLE: begin
`ifdef LED_BANK_DRIVER_BLINK_EN
        if (rpend_q) begin
          rpend_d = 1'b0;
          inst_d = rst_need ? rst_inst : '0;
          inst_en_d = rst_need;
          shadow_d = target_q;
          state_d = rst_need ? ST_ISSUE : ST_IDLE;
        end else if (bpend_q) begin
          bpend_d = 1'b0;
          inst_d = {OP_LDI, ~shadow_q};
          inst_en_d = 1'b1;
          shadow_d = ~shadow_q;
          state_d = ST_ISSUE;
        end else
`endif
        if (acc && req_need) begin
          inst_d = req_inst;
          inst_en_d = 1'b1;
          shadow_d = bus.req_value;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        gap_d = '0;
        state_d = GAP > 0 ? ST_GAP : ST_IDLE;
      end
      default: begin
        gap_d = gap_q + 8'd1;
        state_d = gap_q == 8'(GAP - 1) ? ST_IDLE : ST_GAP;
      end
    endcase
`ifdef LED_BANK_DRIVER_BLINK_EN
    if (bus.blink && !blink_q) bcnt_d = '0;
    else if (bus.blink) bcnt_d = bcnt_q == BW'(BLINK_PERIOD - 1) ? '0 : bcnt_q + 1'b1;
    if (bus.blink && blink_q && bcnt_q == BW'(BLINK_PERIOD - 1)) bpend_d = 1'b1;
    if (!bus.blink && blink_q) begin
      bpend_d = 1'b0;
      rpend_d = 1'b1;
    end
    ready_d = state_d == ST_IDLE && !bpend_d && !rpend_d;
`else
    ready_d = state_d == ST_IDLE;
`endif
  end
  // state and output registers, cleared immediately on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RESET;
      gap_q <= '0;
      ready_q <= 1'b0;
      inst_q <= '0;
      inst_en_q <= 1'b0;
      shadow_q <= '0;
`ifdef LED_BANK_DRIVER_BLINK_EN
      target_q <= '0;
      blink_q <= 1'b0;
      bcnt_q <= '0;
      bpend_q <= 1'b0;
      rpend_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gap_q <= gap_d;
      ready_q <= ready_d;
      inst_q <= inst_d;
      inst_en_q <= inst_en_d;
      shadow_q <= shadow_d;
`ifdef LED_BANK_DRIVER_BLINK_EN
      target_q <= target_d;
      blink_q <= bus.blink;
      bcnt_q <= bcnt_d;
      bpend_q <= bpend_d;
      rpend_q <= rpend_d;
`endif
    end
  end
endmodule

// File: tb/tb_led_bank_driver.sv
// tb_led_bank_driver: scoreboard bench for led_bank_driver (blink scenario only with LED_BANK_DRIVER_BLINK_EN)
module tb_led_bank_driver;
`ifdef LED_BANK_DRIVER_BLINK_EN
  localparam int GAP = 0;
`else
  localparam int GAP = 3;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [11:0] exp_q[$];
  int en_cyc[$];
  logic [11:0] mon_e;
  always #5 clk = ~clk;
  led_bank_driver_if bus();
`ifdef LED_BANK_DRIVER_BLINK_EN
  led_bank_driver #(.GAP(GAP), .BLINK_PERIOD(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`else
  led_bank_driver #(.GAP(GAP)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif
  always @(posedge clk) cyc <= cyc + 1;
  // every issued instruction must match the oldest expected one; idle cycles must show inst=0
  always @(negedge clk) begin
    checks++;
    if (bus.inst_en === 1'b1) begin
      en_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_inst: got inst_en with inst=%h, required no instruction", bus.inst);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.inst !== mon_e) begin
          errors++;
          $display("FAIL inst_value: got %h, required %h", bus.inst, mon_e);
        end
      end
    end else if (bus.inst !== 12'h000) begin
      errors++;
      $display("FAIL inst_idle_zero: got %h, required 000", bus.inst);
    end
  end
  task automatic send(input logic [7:0] v, input bit push, input logic [11:0] e, output int waits);
    waits = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_value = v;
    while (bus.req_ready !== 1'b1 && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (bus.req_ready === 1'b1) begin
      if (push) exp_q.push_back(e);
      @(posedge clk);
      #1;
    end
    bus.req_valid = 1'b0;
  endtask
  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_value = 8'h00;
`ifdef LED_BANK_DRIVER_BLINK_EN
    bus.blink = 1'b0;
`endif
    repeat (3) @(negedge clk);
    checks += 5;
    if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b, required 0", bus.req_ready); end
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b, required 1", bus.busy); end
    if (bus.inst_en !== 1'b0) begin errors++; $display("FAIL reset_inst_en: got %b, required 0", bus.inst_en); end
    if (bus.inst !== 12'h000) begin errors++; $display("FAIL reset_inst: got %h, required 000", bus.inst); end
    if (bus.shadow !== 8'h00) begin errors++; $display("FAIL reset_shadow: got %h, required 00", bus.shadow); end
    #1 rst_n = 1'b1;
    #1 checks++;
    if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL reset_hold_cycle: ready got %b, required 0", bus.req_ready); end
    @(posedge clk);
    #1 checks += 2;
    if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_to_idle: ready got %b, required 1", bus.req_ready); end
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b, required 0", bus.busy); end
  endtask
  task automatic test_zero_request();
    int w;
    int n0;
    n0 = en_cyc.size();
    for (int i = 0; i < 2; i++) begin
      send(8'h00, 1'b0, 12'h000, w);
      checks += 3;
      if (w != 0) begin errors++; $display("FAIL zero_wait: got %0d, required 0", w); end
      if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL zero_ready: got %b, required 1", bus.req_ready); end
      if (bus.shadow !== 8'h00) begin errors++; $display("FAIL zero_shadow: got %h, required 00", bus.shadow); end
    end
    repeat (3) @(negedge clk);
    #1 checks++;
    if (en_cyc.size() != n0) begin errors++; $display("FAIL zero_no_inst: got %0d pulses, required 0", en_cyc.size() - n0); end
  endtask
  task automatic test_encode();
    logic [7:0] vals[5] = '{8'hA5, 8'hA4, 8'h24, 8'h2C, 8'h2D};
    logic [11:0] insts[5] = '{12'h1A5, 12'h200, 12'h900, 12'h501, 12'h201};
    int w;
    int n0;
    for (int i = 0; i < 5; i++) begin
      n0 = en_cyc.size();
      send(vals[i], 1'b1, insts[i], w);
      drain();
      checks += 4;
      if (w >= 50) begin errors++; $display("FAIL encode_accept_timeout: value %h not accepted", vals[i]); end
      if (exp_q.size() != 0) begin errors++; $display("FAIL encode_drain: got %0d pending, required 0", exp_q.size()); exp_q.delete(); end
      if (bus.shadow !== vals[i]) begin errors++; $display("FAIL encode_shadow: got %h, required %h", bus.shadow, vals[i]); end
      if (en_cyc.size() != n0 + 1) begin errors++; $display("FAIL encode_pulses: got %0d, required 1", en_cyc.size() - n0); end
    end
  endtask
  task automatic test_back_to_back();
    int w;
    int n0;
    n0 = en_cyc.size();
    send(8'hFF, 1'b1, 12'h1FF, w);
    send(8'h00, 1'b1, 12'h100, w);
    drain();
    checks += 4;
    if (w != GAP + 1) begin errors++; $display("FAIL b2b_ready_low: got %0d cycles, required %0d", w, GAP + 1); end
    if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_drain: got %0d pending, required 0", exp_q.size()); exp_q.delete(); end
    if (bus.shadow !== 8'h00) begin errors++; $display("FAIL b2b_shadow: got %h, required 00", bus.shadow); end
    if (en_cyc.size() != n0 + 2) begin errors++; $display("FAIL b2b_pulses: got %0d, required 2", en_cyc.size() - n0); end
    else if (en_cyc[n0 + 1] - en_cyc[n0] != GAP + 2) begin
      checks++;
      errors++;
      $display("FAIL b2b_spacing: got %0d, required %0d", en_cyc[n0 + 1] - en_cyc[n0], GAP + 2);
    end else checks++;
  endtask
  task automatic test_reset_issue();
    int w;
    send(8'h55, 1'b0, 12'h000, w);
    checks += 2;
    if (bus.inst_en !== 1'b1) begin errors++; $display("FAIL rst_issue_en: got %b, required 1", bus.inst_en); end
    if (bus.inst !== 12'h155) begin errors++; $display("FAIL rst_issue_inst: got %h, required 155", bus.inst); end
    #1 rst_n = 1'b0;
    #1 checks += 4;
    if (bus.inst_en !== 1'b0) begin errors++; $display("FAIL rst_async_en: got %b, required 0", bus.inst_en); end
    if (bus.inst !== 12'h000) begin errors++; $display("FAIL rst_async_inst: got %h, required 000", bus.inst); end
    if (bus.shadow !== 8'h00) begin errors++; $display("FAIL rst_async_shadow: got %h, required 00", bus.shadow); end
    if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL rst_async_ready: got %b, required 0", bus.req_ready); end
    @(negedge clk);
    #1 rst_n = 1'b1;
    #1 checks++;
    if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL rst_release_hold: got %b, required 0", bus.req_ready); end
    @(posedge clk);
    #1 checks += 2;
    if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_release_idle: got %b, required 1", bus.req_ready); end
    if (bus.shadow !== 8'h00) begin errors++; $display("FAIL rst_release_shadow: got %h, required 00", bus.shadow); end
  endtask
`ifdef LED_BANK_DRIVER_BLINK_EN
  task automatic test_blink();
    int w;
    int n0;
    send(8'h0F, 1'b1, 12'h10F, w);
    drain();
    n0 = en_cyc.size();
    exp_q.push_back(12'h1F0);
    exp_q.push_back(12'h10F);
    exp_q.push_back(12'h1F0);
    bus.blink = 1'b1;
    drain();
    checks += 3;
    if (exp_q.size() != 0) begin errors++; $display("FAIL blink_drain: got %0d pending, required 0", exp_q.size()); exp_q.delete(); end
    if (bus.shadow !== 8'hF0) begin errors++; $display("FAIL blink_shadow: got %h, required F0", bus.shadow); end
    if (en_cyc.size() < n0 + 3) begin errors++; $display("FAIL blink_pulses: got %0d, required 3", en_cyc.size() - n0); end
    else begin
      checks += 2;
      if (en_cyc[n0 + 1] - en_cyc[n0] != 4) begin errors++; $display("FAIL blink_spacing1: got %0d, required 4", en_cyc[n0 + 1] - en_cyc[n0]); end
      if (en_cyc[n0 + 2] - en_cyc[n0 + 1] != 4) begin errors++; $display("FAIL blink_spacing2: got %0d, required 4", en_cyc[n0 + 2] - en_cyc[n0 + 1]); end
    end
    bus.blink = 1'b0;
    exp_q.push_back(12'h10F);
    send(8'h3C, 1'b1, 12'h13C, w);
    drain();
    checks += 3;
    if (w < 1 || w >= 50) begin errors++; $display("FAIL restore_priority_wait: got %0d, required 1..49", w); end
    if (exp_q.size() != 0) begin errors++; $display("FAIL restore_drain: got %0d pending, required 0", exp_q.size()); exp_q.delete(); end
    if (bus.shadow !== 8'h3C) begin errors++; $display("FAIL restore_shadow: got %h, required 3C", bus.shadow); end
  endtask
`endif
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset();
    test_zero_request();
    test_encode();
    test_back_to_back();
    test_reset_issue();
`ifdef LED_BANK_DRIVER_BLINK_EN
    test_blink();
`endif
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
